inertial_sensor_intf: RTL and testbench

Upstream front end of the pitch integrator. It brings up the 6-axis inertial sensor over an external SPI master after reset. It then waits for the sensor's data-ready interrupt and reads pitch rate and Z-accel as two bytes each. It presents both as 16-bit words with a one-cycle vld strobe, which feeds the integrator's vld/ptch_rt/AZ inputs directly.

---
 rtl/inertial_sensor_intf_if.sv | 34 +++
 rtl/inertial_sensor_intf.sv | 169 ++++++++++++++++
 tb/tb_inertial_sensor_intf.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inertial_sensor_intf_if.sv
// rtl/inertial_sensor_intf_if.sv - sensor-side SPI handshake and sample output bundle
// master: the interface block; slave: the SPI master / integrator / sensor side.
interface inertial_sensor_intf_if;
  logic        INT;
  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_resp;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        vld;

  modport master (
    input  INT,
    input  spi_done,
    input  spi_resp,
    output spi_wrt,
    output spi_cmd,
    output ptch_rt,
    output AZ,
    output vld
  );

  modport slave (
    output INT,
    output spi_done,
    output spi_resp,
    input  spi_wrt,
    input  spi_cmd,
    input  ptch_rt,
    input  AZ,
    input  vld
  );
endinterface

// File: rtl/inertial_sensor_intf.sv
// rtl/inertial_sensor_intf.sv - inertial sensor bring-up and pitch-rate / Z-accel reader
// Powers up the sensor over SPI, then reads four bytes per data-ready interrupt.
module inertial_sensor_intf #(
  parameter int               TMR_W     = 16,
  parameter logic [TMR_W-1:0] INIT_WAIT = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  inertial_sensor_intf_if.master sens_io
);

  typedef enum logic [3:0] {
    PWRUP,
    INIT1,
    INIT2,
    INIT3,
    INIT4,
    WAIT_INT,
    RD_PL,
    RD_PH,
    RD_AL,
    RD_AH
  } state_t;

  localparam logic [15:0] CMD_INIT1 = 16'h0D02;
  localparam logic [15:0] CMD_INIT2 = 16'h1053;
  localparam logic [15:0] CMD_INIT3 = 16'h1150;
  localparam logic [15:0] CMD_INIT4 = 16'h1460;

  localparam logic [7:0] RD_FLAG = 8'h80;
  localparam logic [7:0] ADDR_PL = 8'h22;
  localparam logic [7:0] ADDR_PH = 8'h23;
  localparam logic [7:0] ADDR_AL = 8'h2C;
  localparam logic [7:0] ADDR_AH = 8'h2D;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             int_ff1_q, int_ff2_q;
  logic [7:0]       pl_q, pl_d;
  logic [7:0]       ph_q, ph_d;
  logic [7:0]       al_q, al_d;
  logic [15:0]      ptch_rt_q, ptch_rt_d;
  logic [15:0]      az_q, az_d;
  logic             vld_q, vld_d;
  logic             spi_wrt_q, spi_wrt_d;
  logic [15:0]      spi_cmd_q, spi_cmd_d;
  logic             xact_done;
  logic [7:0]       resp_byte;
  logic             unused_resp_hi;

  function automatic logic [15:0] cmd_for(input state_t s);
    case (s)
      INIT1:   cmd_for = CMD_INIT1;
      INIT2:   cmd_for = CMD_INIT2;
      INIT3:   cmd_for = CMD_INIT3;
      INIT4:   cmd_for = CMD_INIT4;
      RD_PL:   cmd_for = {ADDR_PL | RD_FLAG, 8'h00};
      RD_PH:   cmd_for = {ADDR_PH | RD_FLAG, 8'h00};
      RD_AL:   cmd_for = {ADDR_AL | RD_FLAG, 8'h00};
      RD_AH:   cmd_for = {ADDR_AH | RD_FLAG, 8'h00};
      default: cmd_for = 16'h0000;
    endcase
  endfunction

  function automatic logic issues_cmd(input state_t s);
    issues_cmd = (s != PWRUP) && (s != WAIT_INT);
  endfunction

  // A done coincident with our own wrt cannot belong to the transaction just
  // launched, so it is dropped rather than advancing the FSM.
  assign xact_done      = sens_io.spi_done && !spi_wrt_q;
  assign resp_byte      = sens_io.spi_resp[7:0];
  assign unused_resp_hi = ^sens_io.spi_resp[15:8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= PWRUP;
      tmr_q     <= '0;
      int_ff1_q <= 1'b0;
      int_ff2_q <= 1'b0;
      pl_q      <= 8'h00;
      ph_q      <= 8'h00;
      al_q      <= 8'h00;
      ptch_rt_q <= 16'h0000;
      az_q      <= 16'h0000;
      vld_q     <= 1'b0;
      spi_wrt_q <= 1'b0;
      spi_cmd_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      int_ff1_q <= sens_io.INT;
      int_ff2_q <= int_ff1_q;
      pl_q      <= pl_d;
      ph_q      <= ph_d;
      al_q      <= al_d;
      ptch_rt_q <= ptch_rt_d;
      az_q      <= az_d;
      vld_q     <= vld_d;
      spi_wrt_q <= spi_wrt_d;
      spi_cmd_q <= spi_cmd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    pl_d      = pl_q;
    ph_d      = ph_q;
    al_d      = al_q;
    ptch_rt_d = ptch_rt_q;
    az_d      = az_q;
    vld_d     = 1'b0;
    spi_wrt_d = 1'b0;
    spi_cmd_d = spi_cmd_q;

    case (state_q)
      PWRUP: begin
        if (tmr_q == INIT_WAIT) state_d = INIT1;
        else                    tmr_d   = tmr_q + 1'b1;
      end
      INIT1:    if (xact_done) state_d = INIT2;
      INIT2:    if (xact_done) state_d = INIT3;
      INIT3:    if (xact_done) state_d = INIT4;
      INIT4:    if (xact_done) state_d = WAIT_INT;
      WAIT_INT: if (int_ff2_q) state_d = RD_PL;
      RD_PL: begin
        if (xact_done) begin
          pl_d    = resp_byte;
          state_d = RD_PH;
        end
      end
      RD_PH: begin
        if (xact_done) begin
          ph_d    = resp_byte;
          state_d = RD_AL;
        end
      end
      RD_AL: begin
        if (xact_done) begin
          al_d    = resp_byte;
          state_d = RD_AH;
        end
      end
      RD_AH: begin
        // Both words update on this single edge so a consumer never sees a torn sample.
        if (xact_done) begin
          ptch_rt_d = {ph_q, pl_q};
          az_d      = {resp_byte, al_q};
          vld_d     = 1'b1;
          state_d   = WAIT_INT;
        end
      end
      default: state_d = PWRUP;
    endcase

    if ((state_d != state_q) && issues_cmd(state_d)) begin
      spi_wrt_d = 1'b1;
      spi_cmd_d = cmd_for(state_d);
    end
  end

  assign sens_io.spi_wrt = spi_wrt_q;
  assign sens_io.spi_cmd = spi_cmd_q;
  assign sens_io.ptch_rt = ptch_rt_q;
  assign sens_io.AZ      = az_q;
  assign sens_io.vld     = vld_q;

endmodule

// File: tb/tb_inertial_sensor_intf.sv
// tb/tb_inertial_sensor_intf.sv - self-checking bench for inertial_sensor_intf
// SPI slave / sensor register model plus protocol monitor; scenario tasks check against it.
module tb_inertial_sensor_intf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  inertial_sensor_intf_if ifc ();

  inertial_sensor_intf #(
    .TMR_W    (16),
    .INIT_WAIT(16'd16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sens_io(ifc)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Sensor register contents and SPI latency, set by the scenarios.
  int         spi_lat = 20;
  logic [7:0] b_pl = 8'h00, b_ph = 8'h00, b_al = 8'h00, b_ah = 8'h00;
  int         stray_req = 0;

  // Written only by the model/monitor process.
  int          cyc = 0;
  bit          pend = 0;
  int          cnt = 0;
  logic [15:0] cur_cmd = 16'h0;
  int          stray_ack = 0;
  logic [15:0] cmd_log[$];
  int          wrt_cyc[$];
  logic [31:0] samp_log[$];
  int          vld_cyc_log[$];
  int          vld_cnt = 0;
  int          last_done_cyc = 0;
  int          outstanding_err = 0;
  int          vld_long_err = 0;
  int          hold_err = 0;
  logic        prev_vld = 1'b0;
  logic [31:0] prev_out = 32'h0;

  localparam logic [15:0] INIT_CMDS[4] = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
  localparam logic [15:0] RD_CMDS[4]   = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

  function automatic logic [7:0] sensor_reg(input logic [15:0] cmd);
    case (cmd)
      16'hA200: sensor_reg = b_pl;
      16'hA300: sensor_reg = b_ph;
      16'hAC00: sensor_reg = b_al;
      16'hAD00: sensor_reg = b_ah;
      default:  sensor_reg = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] exp_sample();
    exp_sample = {b_ph, b_pl, b_ah, b_al};
  endfunction

  initial begin
    bit wrt_now;
    ifc.spi_done = 1'b0;
    ifc.spi_resp = 16'h0000;
    forever begin
      @(negedge clk);
      cyc++;
      ifc.spi_done = 1'b0;
      wrt_now = ifc.spi_wrt && !rst;
      if (wrt_now && pend) outstanding_err++;
      if (rst) pend = 0;
      else if (pend) begin
        if (cnt <= 1) begin
          ifc.spi_done  = 1'b1;
          ifc.spi_resp  = {8'($urandom), sensor_reg(cur_cmd)};
          pend          = 0;
          last_done_cyc = cyc;
        end else cnt--;
      end
      if (stray_ack != stray_req) begin
        stray_ack    = stray_req;
        ifc.spi_done = 1'b1;
        ifc.spi_resp = 16'hA5A5;
      end
      if (wrt_now) begin
        cmd_log.push_back(ifc.spi_cmd);
        wrt_cyc.push_back(cyc);
        pend    = 1;
        cnt     = spi_lat;
        cur_cmd = ifc.spi_cmd;
      end
      if (ifc.vld) begin
        vld_cnt++;
        vld_cyc_log.push_back(cyc);
        samp_log.push_back({ifc.ptch_rt, ifc.AZ});
        if (prev_vld) vld_long_err++;
      end
      if (!rst && ({ifc.ptch_rt, ifc.AZ} != prev_out) && !ifc.vld) hold_err++;
      prev_out = {ifc.ptch_rt, ifc.AZ};
      prev_vld = ifc.vld;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_cmds(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (cmd_log.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic wait_vld(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (vld_cnt >= n) begin ok = 1; break; end
    end
  endtask

  task automatic int_glitch();
    @(negedge clk);
    #2 ifc.INT = 1'b1;
    #4 ifc.INT = 1'b0;
  endtask

  int rel_cyc;

  task automatic release_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic test_reset();
    bit ok;
    int c0;
    ifc.INT = 1'b0;
    rst     = 1'b1;
    repeat (3) tick();
    n_cmp++; if (ifc.spi_wrt !== 1'b0)  begin n_err++; $display("FAIL reset_wrt got %b exp 0", ifc.spi_wrt); end
    n_cmp++; if (ifc.spi_cmd !== 16'h0) begin n_err++; $display("FAIL reset_cmd got %h exp 0000", ifc.spi_cmd); end
    n_cmp++; if ({ifc.vld, ifc.ptch_rt, ifc.AZ} !== 33'h0) begin
      n_err++; $display("FAIL reset_out got vld=%b p=%h a=%h exp all 0", ifc.vld, ifc.ptch_rt, ifc.AZ);
    end
    c0 = cmd_log.size();
    release_reset();
    wait_cmds(c0 + 1, 60, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL reset_first_wrt timeout got none exp wrt"); end
    n_cmp++; if (wrt_cyc[c0] !== rel_cyc + 17) begin
      n_err++; $display("FAIL pwrup_delay got %0d exp %0d cycles", wrt_cyc[c0] - rel_cyc, 17);
    end
  endtask

  task automatic test_init();
    bit ok;
    int c0, v0;
    c0 = cmd_log.size() - 1;
    v0 = vld_cnt;
    wait_cmds(c0 + 4, 300, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL init_timeout got %0d cmds exp 4", cmd_log.size() - c0); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cmd_log[c0+i] !== INIT_CMDS[i]) begin
        n_err++; $display("FAIL init_cmd%0d got %h exp %h", i, cmd_log[c0+i], INIT_CMDS[i]);
      end
    end
    repeat (40) tick();
    n_cmp++; if (cmd_log.size() !== c0 + 4) begin
      n_err++; $display("FAIL init_extra_wrt got %0d exp 4", cmd_log.size() - c0);
    end
    n_cmp++; if (vld_cnt !== v0) begin n_err++; $display("FAIL init_vld got %0d exp 0 pulses", vld_cnt - v0); end
  endtask

  task automatic test_idle();
    int c0, v0;
    c0 = cmd_log.size();
    v0 = vld_cnt;
    ifc.INT = 1'b0;
    repeat (1000) tick();
    n_cmp++; if (cmd_log.size() !== c0) begin n_err++; $display("FAIL idle_wrt got %0d exp 0", cmd_log.size() - c0); end
    n_cmp++; if (vld_cnt !== v0) begin n_err++; $display("FAIL idle_vld got %0d exp 0", vld_cnt - v0); end
    n_cmp++; if ({ifc.ptch_rt, ifc.AZ} !== 32'h0) begin
      n_err++; $display("FAIL idle_out got %h/%h exp 0000/0000", ifc.ptch_rt, ifc.AZ);
    end
  endtask

  task automatic test_single_read();
    bit ok;
    int c0, v0;
    b_pl = 8'h34; b_ph = 8'h12; b_al = 8'h78; b_ah = 8'h56;
    c0 = cmd_log.size();
    v0 = vld_cnt;
    ifc.INT = 1'b1;
    wait_cmds(c0 + 1, 10, ok);
    ifc.INT = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rd_start timeout got no wrt exp A200"); end
    wait_vld(v0 + 1, 200, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rd_vld timeout got no vld exp 1"); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cmd_log[c0+i] !== RD_CMDS[i]) begin
        n_err++; $display("FAIL rd_cmd%0d got %h exp %h", i, cmd_log[c0+i], RD_CMDS[i]);
      end
    end
    n_cmp++; if (samp_log[v0] !== exp_sample()) begin
      n_err++; $display("FAIL rd_sample got %h exp %h", samp_log[v0], exp_sample());
    end
    n_cmp++; if (vld_cyc_log[v0] !== last_done_cyc + 1) begin
      n_err++; $display("FAIL rd_vld_timing got %0d exp %0d after done", vld_cyc_log[v0] - last_done_cyc, 1);
    end
    repeat (30) tick();
    n_cmp++; if ({ifc.vld, ifc.ptch_rt, ifc.AZ} !== {1'b0, 32'h12345678}) begin
      n_err++; $display("FAIL rd_hold got vld=%b %h/%h exp 0 1234/5678", ifc.vld, ifc.ptch_rt, ifc.AZ);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int c0, v0, nseq;
    b_pl = 8'hFF; b_ph = 8'h80; b_al = 8'h01; b_ah = 8'h00;
    c0 = cmd_log.size();
    v0 = vld_cnt;
    ifc.INT = 1'b1;
    wait_vld(v0 + 2, 400, ok);
    ifc.INT = 1'b0;
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b2b_timeout got %0d exp 2 samples", vld_cnt - v0); end
    repeat (200) tick();
    nseq = vld_cnt - v0;
    n_cmp++; if (cmd_log.size() - c0 !== 4 * nseq) begin
      n_err++; $display("FAIL b2b_wrt_count got %0d exp %0d", cmd_log.size() - c0, 4 * nseq);
    end
    for (int s = 0; s < nseq; s++) begin
      n_cmp++; if (samp_log[v0+s] !== 32'h80FF0001) begin
        n_err++; $display("FAIL b2b_sample%0d got %h exp 80FF0001", s, samp_log[v0+s]);
      end
    end
    for (int i = 0; i < 4 * nseq; i++) begin
      n_cmp++; if (cmd_log[c0+i] !== RD_CMDS[i%4]) begin
        n_err++; $display("FAIL b2b_cmd%0d got %h exp %h", i, cmd_log[c0+i], RD_CMDS[i%4]);
      end
    end
    n_cmp++; if (wrt_cyc[c0+4] !== vld_cyc_log[v0] + 1) begin
      n_err++; $display("FAIL b2b_restart got %0d exp 1 cycle after vld", wrt_cyc[c0+4] - vld_cyc_log[v0]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int c0, c1, v0;
    b_pl = 8'hA1; b_ph = 8'hB2; b_al = 8'hC3; b_ah = 8'hD4;
    c0 = cmd_log.size();
    v0 = vld_cnt;
    ifc.INT = 1'b1;
    wait_cmds(c0 + 4, 300, ok);
    ifc.INT = 1'b0;
    n_cmp++; if (!ok || cmd_log[c0+3] !== 16'hAD00) begin
      n_err++; $display("FAIL rstmid_reach got %h exp AD00", cmd_log[c0+3]);
    end
    repeat (5) tick();
    rst = 1'b1;
    repeat (2) tick();
    n_cmp++; if ({ifc.spi_wrt, ifc.spi_cmd, ifc.vld, ifc.ptch_rt, ifc.AZ} !== 50'h0) begin
      n_err++; $display("FAIL rstmid_clear got wrt=%b cmd=%h vld=%b %h/%h exp all 0",
                        ifc.spi_wrt, ifc.spi_cmd, ifc.vld, ifc.ptch_rt, ifc.AZ);
    end
    c1 = cmd_log.size();
    release_reset();
    repeat (3) tick();
    stray_req++;
    wait_cmds(c1 + 4, 300, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_reinit timeout got %0d exp 4", cmd_log.size() - c1); end
    n_cmp++; if (wrt_cyc[c1] !== rel_cyc + 17) begin
      n_err++; $display("FAIL rstmid_pwrup got %0d exp %0d cycles", wrt_cyc[c1] - rel_cyc, 17);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cmd_log[c1+i] !== INIT_CMDS[i]) begin
        n_err++; $display("FAIL rstmid_cmd%0d got %h exp %h", i, cmd_log[c1+i], INIT_CMDS[i]);
      end
    end
    n_cmp++; if (vld_cnt !== v0 || {ifc.ptch_rt, ifc.AZ} !== 32'h0) begin
      n_err++; $display("FAIL rstmid_out got vld+%0d %h/%h exp 0 0000/0000", vld_cnt - v0, ifc.ptch_rt, ifc.AZ);
    end
  endtask

  task automatic test_int_glitch();
    bit ok;
    int c0, v0;
    repeat (40) tick();
    b_pl = 8'($urandom); b_ph = 8'($urandom); b_al = 8'($urandom); b_ah = 8'($urandom);
    c0 = cmd_log.size();
    v0 = vld_cnt;
    int_glitch();
    wait_cmds(c0 + 2, 60, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL glitch_caught got %0d wrt exp >=2", cmd_log.size() - c0); end
    int_glitch();
    wait_vld(v0 + 1, 200, ok);
    repeat (60) tick();
    n_cmp++; if (cmd_log.size() - c0 !== 4 || vld_cnt - v0 !== 1) begin
      n_err++; $display("FAIL glitch_ignored got %0d wrt %0d vld exp 4 wrt 1 vld", cmd_log.size() - c0, vld_cnt - v0);
    end
    n_cmp++; if (samp_log[v0] !== exp_sample()) begin
      n_err++; $display("FAIL glitch_sample got %h exp %h", samp_log[v0], exp_sample());
    end
  endtask

  task automatic test_random();
    bit ok;
    int c0, v0;
    for (int it = 0; it < 8; it++) begin
      spi_lat = $urandom_range(1, 25);
      b_pl = 8'($urandom); b_ph = 8'($urandom); b_al = 8'($urandom); b_ah = 8'($urandom);
      c0 = cmd_log.size();
      v0 = vld_cnt;
      repeat ($urandom_range(1, 20)) tick();
      ifc.INT = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      ifc.INT = 1'b0;
      wait_vld(v0 + 1, 300, ok);
      repeat (30) tick();
      n_cmp++; if (!ok || samp_log[v0] !== exp_sample()) begin
        n_err++; $display("FAIL rand%0d_sample got %h exp %h", it, samp_log[v0], exp_sample());
      end
      n_cmp++; if (cmd_log.size() - c0 !== 4 || {ifc.ptch_rt, ifc.AZ} !== exp_sample()) begin
        n_err++; $display("FAIL rand%0d_seq got %0d wrt out %h exp 4 wrt out %h",
                          it, cmd_log.size() - c0, {ifc.ptch_rt, ifc.AZ}, exp_sample());
      end
    end
    spi_lat = 20;
  endtask

  task automatic test_protocol();
    n_cmp++; if (outstanding_err !== 0) begin n_err++; $display("FAIL wrt_outstanding got %0d exp 0", outstanding_err); end
    n_cmp++; if (vld_long_err !== 0) begin n_err++; $display("FAIL vld_width got %0d long pulses exp 0", vld_long_err); end
    n_cmp++; if (hold_err !== 0) begin n_err++; $display("FAIL output_hold got %0d changes exp 0", hold_err); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_idle();
    test_single_read();
    test_back_to_back();
    test_reset_mid();
    test_int_glitch();
    test_random();
    test_protocol();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
